board_ram_arbiter: RTL and testbench
====================================

// Module: board_ram_arbiter
// PURPOSE
//  Shares the single-port board RAM (6-bit cell per block, 8-bit address) among three
//  requesters: 0 = row clear engine, 1 = piece placer/collision checker, 2 = VGA renderer.
//  Round-robin arbitration with grant lock: the owner keeps the RAM until it drops its request.
//  Muxes the owner's addr/data/wren onto the RAM and fans ram_Q back to all requesters.
// PARAMETERS
//  ADDR_W    8    RAM address width
//  DATA_W    6    RAM data width
//  IDLE_ADDR 0    address driven to the RAM when there is no owner
//  MAX_HOLD  1024 watchdog limit in cycles (used only with BOARD_ARB_WATCHDOG_EN)
// PORTS
//  clk          in   1       system clock, all state updates on posedge
//  reset        in   1       synchronous, active-high
//  req[2:0]     in   3       per-requester request; hold high for the whole transaction
//  grant[2:0]   out  3       registered one-hot grant
//  addr0/1/2    in   ADDR_W  requester addresses
//  data0/1/2    in   DATA_W  requester write data
//  wren0/1/2    in   1       requester write enables
//  ram_addr     out  ADDR_W  to RAM
//  ram_data     out  DATA_W  to RAM
//  ram_wren     out  1       to RAM
//  owner        out  2       index of current owner; 2'd3 = none
//  busy         out  1       high while any grant is held
//  timeout      out  1       one-cycle pulse on watchdog revoke (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, owner=3, busy=0, timeout=0, last=2 (req0 ranks first),
//    ram_addr=IDLE_ADDR, ram_data=0, ram_wren=0.
//  - States: IDLE, GRANT. In IDLE, if req!=0, the winner is the first set bit scanning
//    last+1, last+2, last (mod 3). Set grant/owner and last=winner; go to GRANT.
//    Latency: req sampled at edge N, grant high after edge N+1.
//  - In GRANT the owner cannot be preempted. When req[owner]=0 at an edge, go to IDLE and
//    clear grant. The next owner is granted no earlier than one edge later, so there is
//    a one-cycle gap with no owner.
//  - RAM mux is combinational from the registered owner. ram_addr/ram_data/ram_wren follow
//    the owner's inputs. ram_wren is forced 0 when there is no owner and in any cycle where
//    req[owner]=0.
//  - ram_Q is not registered here. Read latency is whatever the RAM gives (1 cycle).
//  - A request dropped before it is granted is never granted. Grants are never issued to
//    requesters with req low.
//  - Asserting reset in GRANT revokes the grant at that edge and forces ram_wren=0
//    immediately. Partial writes already made are not undone.
//  - Indices: last and owner are 2 bits; value 3 is never a valid winner.
// CONFIGURATION
//  BOARD_ARB_WATCHDOG_EN defined:
//  - A 16-bit hold counter clears on grant and increments every GRANT cycle.
//  - When it reaches MAX_HOLD-1, the next edge revokes the grant (state goes to IDLE),
//    timeout pulses for 1 cycle, and the ex-owner is masked.
//  - A masked requester is ineligible until it has been seen with req low for at least
//    one edge.
//  BOARD_ARB_WATCHDOG_EN undefined: no counter or mask, timeout tied 0, and the grant is
//  held indefinitely.
// TESTING
//  1 reset held 3 cycles with req=3'b111 -> grant=0, owner=3, ram_wren=0 throughout.
//  2 req=3'b010 from cycle 0 -> grant=3'b010 after edge 1; ram_addr tracks addr1;
//    drop req1 -> grant=0 after next edge.
//  3 req=3'b111 held, each owner releases after 4 cycles then re-requests -> grant order
//    001,010,100,001 with a 1-cycle gap between grants.
//  4 owner 2 writing, req0 rises -> grant stays 3'b100 until req2 falls, then 3'b001.
//  5 owner 1 holds wren1=1 and drops req1 in the same cycle -> ram_wren=0 that cycle,
//    so no RAM write occurs.
//  6 (WATCHDOG_EN, MAX_HOLD=8) req0 held high -> grant revoked after 8 GRANT cycles and
//    timeout=1 for one cycle; req0 is not re-granted until it goes low then high again;
//    a pending req1 is granted 1 cycle after the revoke.

Source files
------------

// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if
//   Bundles the requester side and the RAM side of the board RAM arbiter.
//   Signals:
//     req[2:0]            per-requester request (0 = row clear, 1 = placer, 2 = VGA)
//     grant[2:0]          registered one-hot grant
//     addr0/1/2           requester addresses (ADDR_W)
//     data0/1/2           requester write data (DATA_W)
//     wren0/1/2           requester write enables
//     ram_addr/data/wren  muxed signals toward the single-port RAM
//     owner[1:0]          current owner index, 2'd3 = none
//     busy                a grant is held
//     timeout             one-cycle watchdog revoke pulse
//   Modports: master = requester/RAM environment, slave = arbiter.
interface board_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 6
);
    logic [2:0]        req;
    logic [2:0]        grant;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [DATA_W-1:0] data0, data1, data2;
    logic              wren0, wren1, wren2;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [1:0]        owner;
    logic              busy;
    logic              timeout;

    modport master (
        output req, addr0, addr1, addr2, data0, data1, data2, wren0, wren1, wren2,
        input  grant, ram_addr, ram_data, ram_wren, owner, busy, timeout
    );

    modport slave (
        input  req, addr0, addr1, addr2, data0, data1, data2, wren0, wren1, wren2,
        output grant, ram_addr, ram_data, ram_wren, owner, busy, timeout
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter
//   Shares the single-port board RAM among three requesters (0 = row clear engine,
//   1 = piece placer, 2 = VGA renderer). Round-robin arbitration with grant lock:
//   the owner keeps the RAM until it drops its request. The owner's addr/data/wren
//   are muxed combinationally onto the RAM port; ram_Q is fanned out externally.
//   Ports:
//     clk    system clock, all state on posedge
//     reset  synchronous, active-high
//     bus    board_ram_arbiter_if.slave (requests, grant, RAM mux, status)
//   Optional feature: define BOARD_ARB_WATCHDOG_EN to enable the hold watchdog
//   (revoke after MAX_HOLD grant cycles, timeout pulse, ex-owner masked until it
//   has been seen with its request low).
module board_ram_arbiter #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 6,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = '0,
    parameter int unsigned       MAX_HOLD  = 1024
) (
    input logic                 clk,
    input logic                 reset,
    board_ram_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [1:0] NO_OWNER = 2'd3;

    if (MAX_HOLD < 2 || MAX_HOLD > 65536) begin : g_bad_max_hold
        $error("board_ram_arbiter: MAX_HOLD must be in 2..65536");
    end

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] eligible;
    logic       owner_req;
    logic       revoke;
    logic       sel_wren;

    // First eligible index scanning last+1, last+2, last (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
        logic [1:0] cand;
        logic [1:0] win;
        win = NO_OWNER;
        for (int unsigned k = 1; k <= 3; k++) begin
            cand = 2'((32'(last) + k) % 3);
            if (win == NO_OWNER && elig[cand]) win = cand;
        end
        return win;
    endfunction

    always_comb begin
        owner_req = 1'b0;
        case (owner_q)
            2'd0:    owner_req = bus.req[0];
            2'd1:    owner_req = bus.req[1];
            2'd2:    owner_req = bus.req[2];
            default: owner_req = 1'b0;
        endcase
    end

`ifdef BOARD_ARB_WATCHDOG_EN
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [15:0] hold_cnt;
    logic [2:0]  mask;
    logic        timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= '0;
            mask      <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= (state_q == GRANT) ? hold_cnt + 16'd1 : '0;
            // A mask bit clears once its request is seen low; a revoke masks the ex-owner.
            mask      <= (mask & bus.req) | (revoke ? grant_q : '0);
            timeout_q <= revoke;
        end
    end

    assign eligible = bus.req & ~mask;
    assign revoke   = (state_q == GRANT) && owner_req && (hold_cnt == HOLD_LAST);
`else
    assign eligible = bus.req;
    assign revoke   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= NO_OWNER;
            last_q  <= 2'd2;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (rr_pick(eligible, last_q) != NO_OWNER) begin
                    state_d = GRANT;
                    owner_d = rr_pick(eligible, last_q);
                    last_d  = rr_pick(eligible, last_q);
                    grant_d = 3'b001 << rr_pick(eligible, last_q);
                end
            end
            GRANT: begin
                if (!owner_req || revoke) begin
                    state_d = IDLE;
                    owner_d = NO_OWNER;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: RAM mux from the registered owner
    always_comb begin
        bus.grant    = grant_q;
        bus.owner    = owner_q;
        bus.busy     = (state_q == GRANT);
`ifdef BOARD_ARB_WATCHDOG_EN
        bus.timeout  = timeout_q;
`else
        bus.timeout  = 1'b0;
`endif
        bus.ram_addr = IDLE_ADDR;
        bus.ram_data = '0;
        sel_wren     = 1'b0;
        case (owner_q)
            2'd0: begin bus.ram_addr = bus.addr0; bus.ram_data = bus.data0; sel_wren = bus.wren0; end
            2'd1: begin bus.ram_addr = bus.addr1; bus.ram_data = bus.data1; sel_wren = bus.wren1; end
            2'd2: begin bus.ram_addr = bus.addr2; bus.ram_data = bus.data2; sel_wren = bus.wren2; end
            default: ;
        endcase
        // Write is suppressed the cycle the owner drops its request and while reset is asserted.
        bus.ram_wren = sel_wren & owner_req & ~reset;
    end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against an integer-level reference model of the arbitration rules.
//   Define BOARD_ARB_WATCHDOG_EN to build the DUT and model with the watchdog.
module tb_board_ram_arbiter;
`ifdef BOARD_ARB_WATCHDOG_EN
    localparam int unsigned MH = 8;
    localparam bit          WD = 1'b1;
`else
    localparam int unsigned MH = 1024;
    localparam bit          WD = 1'b0;
`endif
    localparam logic [7:0] IDLE_A = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = '0;
    logic [7:0] a[3];
    logic [5:0] d[3];
    logic       w[3];

    always #5 clk = ~clk;

    board_ram_arbiter_if #(.ADDR_W(8), .DATA_W(6)) bus();

    assign bus.req   = req;
    assign bus.addr0 = a[0];
    assign bus.addr1 = a[1];
    assign bus.addr2 = a[2];
    assign bus.data0 = d[0];
    assign bus.data1 = d[1];
    assign bus.data2 = d[2];
    assign bus.wren0 = w[0];
    assign bus.wren1 = w[1];
    assign bus.wren2 = w[2];

    board_ram_arbiter #(
        .ADDR_W(8), .DATA_W(6), .IDLE_ADDR(IDLE_A), .MAX_HOLD(MH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner as integer (3 = none), rotating priority pointer,
    // hold counter, per-requester mask and timeout flag.
    int m_owner = 3;
    int m_last = 2;
    int m_cnt = 0;
    bit m_mask[3];
    bit m_timeout = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] eg;
        logic [7:0] ea;
        logic [5:0] ed;
        logic       ew;
        eg = '0; ea = IDLE_A; ed = '0; ew = 1'b0;
        if (m_owner != 3) begin
            eg = 3'(1 << m_owner);
            ea = a[m_owner];
            ed = d[m_owner];
            ew = req[m_owner] && w[m_owner] && !reset;
        end
        chk("grant",    bus.grant,    eg);
        chk("owner",    bus.owner,    32'(m_owner));
        chk("busy",     bus.busy,     32'(m_owner != 3));
        chk("timeout",  bus.timeout,  m_timeout);
        chk("ram_addr", bus.ram_addr, ea);
        chk("ram_data", bus.ram_data, ed);
        chk("ram_wren", bus.ram_wren, ew);
    endtask

    task automatic model_edge();
        if (reset) begin
            m_owner = 3; m_last = 2; m_cnt = 0; m_timeout = 1'b0;
            for (int i = 0; i < 3; i++) m_mask[i] = 1'b0;
        end else begin
            m_timeout = 1'b0;
            if (m_owner == 3) begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last + k) % 3;
                    if (m_owner == 3 && req[c] && !m_mask[c]) begin
                        m_owner = c; m_last = c; m_cnt = 0;
                    end
                end
            end else if (!req[m_owner]) begin
                m_owner = 3;
            end else if (WD && m_cnt == int'(MH) - 1) begin
                m_mask[m_owner] = 1'b1;
                m_timeout = 1'b1;
                m_owner = 3;
            end else begin
                m_cnt++;
            end
            for (int i = 0; i < 3; i++) if (!req[i]) m_mask[i] = 1'b0;
        end
    endtask

    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] order[$];
        logic [2:0] exp_ord[4];
        logic [2:0] prev_g;
        int held, direct, g0, to;

        for (int i = 0; i < 3; i++) begin a[i] = 8'(i * 16 + 3); d[i] = 6'(i + 1); w[i] = 1'b0; end

        // 1: reset held with all requests high
        reset = 1'b1; req = 3'b111;
        @(posedge clk); model_edge(); @(negedge clk);
        repeat (3) cycle();
        reset = 1'b0; req = '0;
        cycle();

        // 2: single requester, address tracking, release
        req = 3'b010; a[1] = 8'h11;
        cycle();
        #1 chk("t2_grant_on", bus.grant, 3'b010);
        for (int i = 0; i < 3; i++) begin a[1] = 8'($urandom); d[1] = 6'($urandom); w[1] = 1'b1; cycle(); end
        req = '0;
        cycle();
        #1 chk("t2_grant_off", bus.grant, 3'b000);
        w[1] = 1'b0;

        // 3: all requesting, each owner releases after 4 cycles
        do_reset();
        req = 3'b111; held = 0; direct = 0; prev_g = '0;
        exp_ord = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int c = 0; c < 30; c++) begin
            req = 3'b111;
            if (m_owner != 3) begin
                held++;
                if (held == 4) begin req[m_owner] = 1'b0; held = 0; end
            end
            cycle();
            if (bus.grant != 3'b000 && bus.grant != prev_g) order.push_back(bus.grant);
            if (prev_g != 3'b000 && bus.grant != 3'b000 && bus.grant != prev_g) direct++;
            prev_g = bus.grant;
        end
        chk("t3_count", 32'(order.size() >= 4), 1);
        for (int i = 0; i < 4; i++) if (i < order.size()) chk("t3_order", order[i], exp_ord[i]);
        chk("t3_gap", direct, 0);

        // 4: no preemption of a writing owner
        do_reset();
        req = 3'b100; w[2] = 1'b1; a[2] = 8'h42; d[2] = 6'h2A;
        repeat (3) cycle();
        req = 3'b101;
        for (int i = 0; i < 3; i++) begin cycle(); #1 chk("t4_hold", bus.grant, 3'b100); end
        req = 3'b001;
        cycle();
        #1 chk("t4_gap", bus.grant, 3'b000);
        cycle();
        #1 chk("t4_next", bus.grant, 3'b001);
        req = '0; w[2] = 1'b0;
        repeat (2) cycle();

        // 5: owner drops request while holding wren
        do_reset();
        req = 3'b010; w[1] = 1'b1;
        repeat (2) cycle();
        req = '0;
        #1 chk("t5_wren", bus.ram_wren, 1'b0);
        cycle();
        w[1] = 1'b0;

        // 6: watchdog revoke and masking
        if (WD) begin
            do_reset();
            req = 3'b011; g0 = 0; to = 0;
            for (int i = 0; i < 12; i++) begin
                cycle();
                if (bus.grant == 3'b001) g0++;
                if (bus.timeout === 1'b1) to++;
            end
            chk("t6_hold_cycles", g0, 8);
            chk("t6_timeout_pulses", to, 1);
            chk("t6_next_owner", bus.grant, 3'b010);
            req = 3'b001;
            repeat (2) cycle();
            chk("t6_masked", bus.grant, 3'b000);
            req = 3'b000;
            cycle();
            req = 3'b001;
            cycle();
            chk("t6_regrant", bus.grant, 3'b001);
            req = '0;
            repeat (2) cycle();
        end

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                a[i] = 8'($urandom);
                d[i] = 6'($urandom);
                w[i] = 1'($urandom);
            end
            reset = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
